// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit: ID/EX hazard
// observations flowing in, PC and pipeline-register controls flowing out.
interface hazard_unit_if;
   // Level-sensitive control bundle with no valid/ready handshake: the hazard
   // unit samples every input each cycle and the datapath obeys every control
   // output in the same cycle.
   logic [4:0] id_rs1_address;
   logic [4:0] id_rs2_address;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] ex_rd_address;
   logic       ex_mem_read;
   logic       ex_muldiv_valid;
   logic       ex_branch_taken;

   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_write;
   logic       id_ex_flush;
   logic       ex_mem_flush;

   modport master (
      output id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
      output ex_rd_address, ex_mem_read, ex_muldiv_valid, ex_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
      input  ex_mem_flush
   );

   modport slave (
      input  id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
      input  ex_rd_address, ex_mem_read, ex_muldiv_valid, ex_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
      output ex_mem_flush
   );
endinterface

// File: rtl/hazard_unit.sv
// Load-use, taken-branch and multi-cycle mul/div hazard controller for the
// 5-stage core, with a saturating count of front-end stall cycles.
module hazard_unit #(
   parameter int MULDIV_LATENCY = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_unit_if.slave         bus,
   output logic                 md_busy,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [4:0]           dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam bit          MD_MULTI = (MULDIV_LATENCY > 1);
   localparam int          LOAD_I   = MD_MULTI ? (MULDIV_LATENCY - 2) : 0;
   localparam logic [3:0]  LOAD_CNT = 4'(LOAD_I);

   state_t     state;
   state_t     next_state;
   logic [3:0] md_cnt;
   logic [3:0] next_md_cnt;

   logic       md_start;
   logic       md_hold;
   logic       rs1_hit;
   logic       rs2_hit;
   logic       load_use;

   // Hazard detection terms
   always_comb begin
      md_start = (state == IDLE) && bus.ex_muldiv_valid && MD_MULTI;
      md_hold  = md_start || ((state == BUSY) && (md_cnt != 4'd0));
      rs1_hit  = bus.id_uses_rs1 && (bus.ex_rd_address == bus.id_rs1_address);
      rs2_hit  = bus.id_uses_rs2 && (bus.ex_rd_address == bus.id_rs2_address);
      load_use = bus.ex_mem_read && (bus.ex_rd_address != 5'd0) &&
                 (rs1_hit || rs2_hit);
   end

   always_comb begin
      next_state  = state;
      next_md_cnt = md_cnt;
      unique case (state)
         IDLE: begin
            if (md_start) begin
               next_state  = BUSY;
               next_md_cnt = LOAD_CNT;
            end
         end
         BUSY: begin
            // mul/div and branch inputs are ignored here: EX still holds the
            // same mul/div, so looking at them would retrigger the stall.
            if (md_cnt != 4'd0) begin
               next_md_cnt = md_cnt - 4'd1;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state  = IDLE;
            next_md_cnt = 4'd0;
         end
      endcase
   end

   // Control outputs; priority is mul/div hold, taken branch, load-use
   always_comb begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_write  = 1'b1;
      bus.id_ex_flush  = 1'b0;
      bus.ex_mem_flush = 1'b0;
      if (md_hold) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.id_ex_write  = 1'b0;
         bus.ex_mem_flush = 1'b1;
      end else if ((state == IDLE) && bus.ex_branch_taken) begin
         // Squashing ID also removes any load-use partner it had.
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
      end else if ((state == IDLE) && load_use) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         bus.id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         md_cnt      <= 4'd0;
         stall_count <= '0;
      end else begin
         state  <= next_state;
         md_cnt <= next_md_cnt;
         if (!bus.pc_write && (stall_count != {CNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
         end
      end
   end

   assign md_busy   = (state == BUSY);
   assign dbg_state = {state, md_cnt};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: default DUT plus a 4-bit-counter instance
// for saturation and a latency-1 instance that must never stall.
module tb_hazard_unit;

   localparam logic [5:0] CTRL_DEF  = 6'b110100;
   localparam logic [5:0] CTRL_LU   = 6'b000110;
   localparam logic [5:0] CTRL_BR   = 6'b111110;
   localparam logic [5:0] CTRL_HOLD = 6'b000001;

   logic clk;
   logic rst_n;

   int n_cmp;
   int n_err;

   hazard_unit_if hif();
   hazard_unit_if sif();
   hazard_unit_if lif();

   logic        md_busy;
   logic [31:0] stall_count;
   logic [4:0]  dbg_state;
   logic        s_md_busy;
   logic [3:0]  s_stall_count;
   logic [4:0]  s_dbg_state;
   logic        l_md_busy;
   logic [31:0] l_stall_count;
   logic [4:0]  l_dbg_state;

   hazard_unit #(.MULDIV_LATENCY(4), .CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(hif),
      .md_busy(md_busy), .stall_count(stall_count), .dbg_state(dbg_state)
   );

   hazard_unit #(.MULDIV_LATENCY(4), .CNT_WIDTH(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(sif),
      .md_busy(s_md_busy), .stall_count(s_stall_count), .dbg_state(s_dbg_state)
   );

   hazard_unit #(.MULDIV_LATENCY(1), .CNT_WIDTH(32)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .bus(lif),
      .md_busy(l_md_busy), .stall_count(l_stall_count), .dbg_state(l_dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] ctrl_main();
      return {hif.pc_write, hif.if_id_write, hif.if_id_flush,
              hif.id_ex_write, hif.id_ex_flush, hif.ex_mem_flush};
   endfunction

   // Driver tasks
   task automatic clear_inputs();
      hif.id_rs1_address = 5'd0; hif.id_rs2_address = 5'd0;
      hif.id_uses_rs1 = 1'b0;    hif.id_uses_rs2 = 1'b0;
      hif.ex_rd_address = 5'd0;  hif.ex_mem_read = 1'b0;
      hif.ex_muldiv_valid = 1'b0; hif.ex_branch_taken = 1'b0;
      sif.id_rs1_address = 5'd0; sif.id_rs2_address = 5'd0;
      sif.id_uses_rs1 = 1'b0;    sif.id_uses_rs2 = 1'b0;
      sif.ex_rd_address = 5'd0;  sif.ex_mem_read = 1'b0;
      sif.ex_muldiv_valid = 1'b0; sif.ex_branch_taken = 1'b0;
      lif.id_rs1_address = 5'd0; lif.id_rs2_address = 5'd0;
      lif.id_uses_rs1 = 1'b0;    lif.id_uses_rs2 = 1'b0;
      lif.ex_rd_address = 5'd0;  lif.ex_mem_read = 1'b0;
      lif.ex_muldiv_valid = 1'b0; lif.ex_branch_taken = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_main(), CTRL_DEF);
      end
      n_cmp++;
      if ({md_busy, dbg_state} !== 6'b0) begin
         n_err++; $display("FAIL reset_state got=%b exp=0", {md_busy, dbg_state});
      end
      n_cmp++;
      if (stall_count !== 32'd0) begin
         n_err++; $display("FAIL reset_count got=%0d exp=0", stall_count);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load_use();
      reset_dut();
      hif.ex_mem_read = 1'b1; hif.ex_rd_address = 5'd5;
      hif.id_rs1_address = 5'd5; hif.id_uses_rs1 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_LU) begin
         n_err++; $display("FAIL load_use_rs1 got=%b exp=%b", ctrl_main(), CTRL_LU);
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_cmp++;
      if (stall_count !== 32'd1 || ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL load_use_after got=%0d/%b exp=1/%b", stall_count, ctrl_main(), CTRL_DEF);
      end
      step();
      // Match on rs2 only; rs1 matches but is not used
      hif.ex_mem_read = 1'b1; hif.ex_rd_address = 5'd17;
      hif.id_rs1_address = 5'd17; hif.id_uses_rs1 = 1'b0;
      hif.id_rs2_address = 5'd17; hif.id_uses_rs2 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_LU) begin
         n_err++; $display("FAIL load_use_rs2 got=%b exp=%b", ctrl_main(), CTRL_LU);
      end
      step();
      hif.id_uses_rs2 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_DEF || stall_count !== 32'd2) begin
         n_err++; $display("FAIL load_use_unused got=%b/%0d exp=%b/2", ctrl_main(), stall_count, CTRL_DEF);
      end
      hif.id_uses_rs2 = 1'b1; hif.ex_mem_read = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL no_load got=%b exp=%b", ctrl_main(), CTRL_DEF);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_x0();
      reset_dut();
      hif.ex_mem_read = 1'b1; hif.ex_rd_address = 5'd0;
      hif.id_rs1_address = 5'd0; hif.id_uses_rs1 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL x0_ctrl got=%b exp=%b", ctrl_main(), CTRL_DEF);
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_cmp++;
      if (stall_count !== 32'd0) begin
         n_err++; $display("FAIL x0_count got=%0d exp=0", stall_count);
      end
      step();
   endtask

   task automatic test_branch_mask();
      reset_dut();
      hif.ex_mem_read = 1'b1; hif.ex_rd_address = 5'd9;
      hif.id_rs1_address = 5'd9; hif.id_uses_rs1 = 1'b1;
      hif.ex_branch_taken = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctrl_main() !== CTRL_BR) begin
         n_err++; $display("FAIL branch_mask got=%b exp=%b", ctrl_main(), CTRL_BR);
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_cmp++;
      if (stall_count !== 32'd0 || md_busy !== 1'b0) begin
         n_err++; $display("FAIL branch_count got=%0d/%b exp=0/0", stall_count, md_busy);
      end
      step();
   endtask

   task automatic test_muldiv_single();
      logic [5:0] exp_ctrl;
      logic [4:0] exp_dbg [4] = '{5'b0_0000, 5'b1_0010, 5'b1_0001, 5'b1_0000};
      reset_dut();
      hif.ex_muldiv_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         // A taken branch while BUSY must not disturb the hold or release
         hif.ex_branch_taken = (c >= 2);
         @(negedge clk);
         exp_ctrl = (c < 3) ? CTRL_HOLD : CTRL_DEF;
         n_cmp++;
         if (ctrl_main() !== exp_ctrl || md_busy !== (c >= 1)) begin
            n_err++; $display("FAIL md_single_c%0d got=%b/%b exp=%b/%b", c, ctrl_main(), md_busy, exp_ctrl, (c >= 1));
         end
         n_cmp++;
         if (dbg_state !== exp_dbg[c]) begin
            n_err++; $display("FAIL md_state_c%0d got=%b exp=%b", c, dbg_state, exp_dbg[c]);
         end
         step();
      end
      clear_inputs();
      @(negedge clk);
      n_cmp++;
      if (stall_count !== 32'd3 || md_busy !== 1'b0 || ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL md_single_end got=%0d/%b/%b exp=3/0/%b", stall_count, md_busy, ctrl_main(), CTRL_DEF);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic exp_pc;
      reset_dut();
      hif.ex_muldiv_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_pc = ((c % 4) == 3);
         n_cmp++;
         if (hif.pc_write !== exp_pc || md_busy !== ((c % 4) != 0)) begin
            n_err++; $display("FAIL b2b_c%0d got=%b/%b exp=%b/%b", c, hif.pc_write, md_busy, exp_pc, ((c % 4) != 0));
         end
         step();
      end
      clear_inputs();
      @(negedge clk);
      n_cmp++;
      if (stall_count !== 32'd6) begin
         n_err++; $display("FAIL b2b_count got=%0d exp=6", stall_count);
      end
      step();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      hif.ex_muldiv_valid = 1'b1;
      step();
      @(negedge clk);
      n_cmp++;
      if (md_busy !== 1'b1 || stall_count !== 32'd1) begin
         n_err++; $display("FAIL mid_busy got=%b/%0d exp=1/1", md_busy, stall_count);
      end
      rst_n = 1'b0;
      step();
      @(negedge clk);
      n_cmp++;
      if (md_busy !== 1'b0 || stall_count !== 32'd0 || dbg_state !== 5'd0) begin
         n_err++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0", md_busy, stall_count, dbg_state);
      end
      n_cmp++;
      if (ctrl_main() !== CTRL_HOLD) begin
         n_err++; $display("FAIL mid_reset_idle_comb got=%b exp=%b", ctrl_main(), CTRL_HOLD);
      end
      hif.ex_muldiv_valid = 1'b0;
      #1;
      n_cmp++;
      if (ctrl_main() !== CTRL_DEF) begin
         n_err++; $display("FAIL mid_reset_defaults got=%b exp=%b", ctrl_main(), CTRL_DEF);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_saturation();
      reset_dut();
      sif.ex_mem_read = 1'b1; sif.ex_rd_address = 5'd3;
      sif.id_rs2_address = 5'd3; sif.id_uses_rs2 = 1'b1;
      for (int c = 0; c < 14; c++) step();
      @(negedge clk);
      n_cmp++;
      if (s_stall_count !== 4'd14) begin
         n_err++; $display("FAIL sat_14 got=%0d exp=14", s_stall_count);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (s_stall_count !== 4'd15) begin
         n_err++; $display("FAIL sat_15 got=%0d exp=15", s_stall_count);
      end
      for (int c = 0; c < 20; c++) begin
         step();
         @(negedge clk);
         n_cmp++;
         if (s_stall_count !== 4'd15 || sif.pc_write !== 1'b0) begin
            n_err++; $display("FAIL sat_hold_c%0d got=%0d/%b exp=15/0", c, s_stall_count, sif.pc_write);
         end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_latency_one();
      reset_dut();
      lif.ex_muldiv_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (lif.pc_write !== 1'b1 || lif.ex_mem_flush !== 1'b0 || l_md_busy !== 1'b0) begin
            n_err++; $display("FAIL lat1_c%0d got=%b/%b/%b exp=1/0/0", c, lif.pc_write, lif.ex_mem_flush, l_md_busy);
         end
         step();
      end
      n_cmp++;
      if (l_stall_count !== 32'd0) begin
         n_err++; $display("FAIL lat1_count got=%0d exp=0", l_stall_count);
      end
      clear_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_x0();
      test_branch_mask();
      test_muldiv_single();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      test_latency_one();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside the forwarding unit and covers the cases forwarding cannot resolve. It detects load-use hazards in ID, squashes wrong-path instructions on taken branches, and freezes the front of the pipeline while a multi-cycle mul/div occupies EX. It drives the write-enable and flush controls of the PC and the pipeline registers, and keeps a saturating stall-cycle counter.

## Interface
- MULDIV_LATENCY, 4: total EX cycles a mul/div instruction occupies; legal range 1..15.
- CNT_WIDTH, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- id_rs1_address  in  5  rs1 of the instruction in ID.
- id_rs2_address  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd_address  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_muldiv_valid  in  1  EX instruction is a mul/div; held stable while EX is frozen.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX register loads a bubble.
- ex_mem_flush  out  1  EX/MEM register loads a bubble.
- md_busy  out  1  a multi-cycle op is in progress (state BUSY).
- stall_count  out  CNT_WIDTH  cycles with pc_write=0 since reset; saturates at all-ones.

## Operation
- State machine: IDLE, BUSY. A 4-bit down-counter md_cnt accompanies it.
- IDLE to BUSY: taken when ex_muldiv_valid=1 and MULDIV_LATENCY>1; md_cnt is loaded with MULDIV_LATENCY-2.
- BUSY, md_cnt>0: md_cnt decrements.
- BUSY, md_cnt=0: returns to IDLE.
- In BUSY, ex_muldiv_valid and ex_branch_taken are ignored. The EX instruction is the same mul/div, so this prevents a retrigger.
- Defaults (no hazard): pc_write=1, if_id_write=1, id_ex_write=1, all flushes=0.
- Priority: mul/div hold, then taken branch, then load-use.
- Mul/div hold applies when (IDLE and ex_muldiv_valid and MULDIV_LATENCY>1) or (BUSY and md_cnt!=0):
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1.
  - if_id_flush=0, id_ex_flush=0.
- Release cycle (BUSY with md_cnt=0): default outputs, so the mul/div advances to MEM.
- Taken branch (IDLE, ex_branch_taken=1, no hold): if_id_flush=1, id_ex_flush=1, pc_write=1. Any load-use match in the same cycle is suppressed, because the ID instruction is squashed.
- Load-use (IDLE, no branch, no hold): fires when ex_mem_read=1, ex_rd_address!=0, and (ex_rd_address==id_rs1_address with id_uses_rs1) or (ex_rd_address==id_rs2_address with id_uses_rs2).
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - Lasts exactly one cycle, because the load leaves EX on the next edge.
- stall_count increments on each edge where pc_write=0, unless it is already all-ones.

## Timing
- All control outputs are combinational from the current state and the inputs. No added latency.
- Reset values: state=IDLE, md_cnt=0, stall_count=0, md_busy=0.
- During reset, outputs take their IDLE combinational values.
- A mul/div freezes the front end for exactly MULDIV_LATENCY-1 cycles. It leaves EX on the MULDIV_LATENCY-th cycle after entering EX.
- MULDIV_LATENCY=1: BUSY is never entered and no stall occurs.
- Back-to-back mul/div: the second one enters EX on the cycle after release and sees IDLE, so a new full stall begins.
- Reset asserted in BUSY: the next state is IDLE, md_cnt=0, and the counter clears. Any partial mul/div is discarded by the pipeline reset.
- rd=x0 never causes a load-use stall.

## Test plan
- Load-use hazard:
  - Stimulus: ex_mem_read=1, ex_rd_address=5, id_rs1_address=5, id_uses_rs1=1.
  - Response: one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count goes 0 to 1.
- Load-use with rd=x0:
  - Stimulus: same as above with ex_rd_address=0 and id_rs1_address=0.
  - Response: no stall; stall_count stays 0.
- Branch masks load-use:
  - Stimulus: a load-use match and ex_branch_taken=1 in the same cycle.
  - Response: if_id_flush=1, id_ex_flush=1, pc_write=1; stall_count unchanged.
- Single mul/div at MULDIV_LATENCY=4:
  - Stimulus: ex_muldiv_valid=1 held for 4 cycles.
  - Response: cycles 0-2 have pc_write=0, id_ex_write=0, ex_mem_flush=1; md_busy=1 on cycles 1-3; cycle 3 shows defaults; stall_count=3.
- Back-to-back mul/div:
  - Stimulus: ex_muldiv_valid=1 for 8 cycles.
  - Response: two stall windows of 3 cycles each, separated by one release cycle; stall_count=6.
- Reset mid-operation:
  - Stimulus: rst_n=0 on cycle 1 of BUSY.
  - Response: next cycle md_busy=0, stall_count=0, and outputs return to defaults once ex_muldiv_valid=0.
- Saturation: force stall_count to all-ones with CNT_WIDTH=4, then apply 20 stall cycles; stall_count must stay at 15.
